regfile_sequencer: RTL and testbench
====================================

REGFILE_SEQUENCER -- requirements
Module: regfile_sequencer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports exactly as below.
- clk_main  input  1  system clock; all state changes on rising edge.
- reset  input  1  asynchronous, active-high reset.
- instr  input  16  instruction word: [15:12] opcode, [11:8] DA, [7:4] AA, [3:0] BA/imm-low.
- instr_valid  input  1  instr is presented.
- instr_ready  output  1  block can accept an instruction.
- rf_en  output  1  register-file enable.
- rf_rw  output  2  register-file mode {RD,WR}: 10 = read, 01 = write.
- rf_da  output  4  destination address.
- rf_aa  output  4  A read address.
- rf_ba  output  4  B read address.
- rf_d  output  16  write data.
- rf_a  input  16  register-file A output, registered by the register file on the read edge.
- rf_b  input  16  register-file B output, registered by the register file on the read edge.
- done  output  1  one-cycle pulse when an instruction retires.
- illegal  output  1  one-cycle pulse, coincident with done, for an undefined opcode.
- zero  output  1  last ALU result was 0.
- carry  output  1  last ADD carry-out, or last SUB borrow.

Function
REQ-002 The block SHALL use FSM states IDLE, READ, EXEC, WRITE, DONE.
REQ-003 The block SHALL drive instr_ready = 1 only in IDLE, and SHALL accept an instruction on an edge where instr_valid & instr_ready; it SHALL latch instr internally at that edge.
REQ-004 Opcodes SHALL be: 0 NOP; 1 ADD A+B; 2 SUB A-B; 3 AND; 4 OR; 5 XOR; 6 MOV A; 7 NOT A; 8 SHL A,1 (zero fill); 9 SHR A,1 (zero fill); A LDI, D = {8'h00, instr[7:0]}; B-F illegal.
REQ-005 IDLE transitions SHALL be: ALU opcodes 1-9 -> READ; LDI -> WRITE; NOP and illegal -> DONE.
REQ-006 READ SHALL last one cycle, driving rf_en = 1, rf_rw = 10, rf_aa = AA and rf_ba = BA, then go to EXEC.
REQ-007 EXEC SHALL last one cycle, drive rf_en = 0 and rf_rw = 00, compute the result from rf_a/rf_b, register the result, zero and carry at the exit edge, then go to WRITE.
REQ-008 WRITE SHALL last one cycle, driving rf_en = 1, rf_rw = 01, rf_da = DA and rf_d = the result (or the LDI immediate), then go to DONE.
REQ-009 DONE SHALL last one cycle, drive done = 1 (plus illegal = 1 for opcodes B-F), and return to IDLE.
REQ-010 Instruction latency SHALL be: ALU op, 4 cycles from accept edge to done; LDI, 2 cycles; NOP/illegal, 1 cycle. Throughput SHALL be one instruction per latency + 1 cycles.
REQ-011 Arithmetic SHALL be 16-bit modulo. ADD carry = bit 16 of the 17-bit sum; SUB carry = 1 when A < B unsigned. For opcodes 3-9, carry SHALL be 0.
REQ-012 zero and carry SHALL update only on opcodes 1-9 and hold otherwise; LDI/NOP/illegal SHALL NOT alter them.
REQ-013 Outside READ/WRITE, rf_en SHALL be 0 and rf_rw SHALL be 00. Addresses and rf_d SHALL hold their last values.
REQ-014 When AA, BA and DA are the same register, the write SHALL use the value read in READ; there SHALL be no forwarding.
REQ-015 Illegal and NOP instructions SHALL never assert rf_en.
REQ-016 instr_valid while not in IDLE SHALL be ignored, with no queueing.

Reset
REQ-017 reset asserted SHALL immediately force IDLE, rf_en = 0, rf_rw = 00, rf_da/rf_aa/rf_ba = 0, rf_d = 0, done = 0, illegal = 0, zero = 0, carry = 0, instr_ready = 1 after release.
REQ-018 Reset mid-instruction SHALL abort it, with no subsequent write and no done pulse.
REQ-019 The first accept SHALL be possible on the first rising edge after reset deassertion.

Verification
REQ-020 A bench paired with a register-file model SHALL cover at least:
- LDI R3 = 0x5A (instr 0xA35A) -> rf_rw = 01, rf_da = 3, rf_d = 0x005A in cycle 1 after accept; done in cycle 2.
- R1 = 0xFFFF, R2 = 0x0001, ADD R4,R1,R2 (0x1412) -> READ aa = 1/ba = 2; write R4 = 0x0000; zero = 1, carry = 1; done 4 cycles after accept.
- R1 = 0x0003, R2 = 0x0005, SUB R5,R1,R2 (0x2512) -> R5 = 0xFFFE, carry = 1, zero = 0.
- Opcode 0xF123 -> done and illegal high together 1 cycle after accept; rf_en stays 0; flags unchanged.
- Reset asserted during EXEC of ADD -> outputs zero at once; no rf_rw = 01 follows; no done.
- instr_valid held high continuously with NOP (0x0000) -> accepts every 2 cycles; instr_ready low in DONE.

Source files
------------

// File: rtl/regfile_sequencer.sv
// Register-file instruction sequencer: accepts one 16-bit instruction at a
// time, reads its operands, runs a small ALU and writes the result back.
// Each instruction then retires with a one-cycle done pulse.
module regfile_sequencer (
  input  logic        clk_main,
  input  logic        reset,
  input  logic [15:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  output logic        rf_en,
  output logic [1:0]  rf_rw,
  output logic [3:0]  rf_da,
  output logic [3:0]  rf_aa,
  output logic [3:0]  rf_ba,
  output logic [15:0] rf_d,
  input  logic [15:0] rf_a,
  input  logic [15:0] rf_b,
  output logic        done,
  output logic        illegal,
  output logic        zero,
  output logic        carry
);

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_AND = 4'h3;
  localparam logic [3:0] OP_OR  = 4'h4;
  localparam logic [3:0] OP_XOR = 4'h5;
  localparam logic [3:0] OP_MOV = 4'h6;
  localparam logic [3:0] OP_NOT = 4'h7;
  localparam logic [3:0] OP_SHL = 4'h8;
  localparam logic [3:0] OP_SHR = 4'h9;
  localparam logic [3:0] OP_LDI = 4'hA;

  localparam logic [1:0] RW_IDLE  = 2'b00;
  localparam logic [1:0] RW_READ  = 2'b10;
  localparam logic [1:0] RW_WRITE = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_EXEC,
    S_WRITE,
    S_DONE
  } state_t;

  // ALU: returns {carry, result}; carry is only meaningful for ADD/SUB.
  function automatic logic [16:0] alu_op(input logic [3:0] op,
                                         input logic [15:0] a,
                                         input logic [15:0] b);
    logic [16:0] r;
    r = '0;
    case (op)
      OP_ADD:  r = {1'b0, a} + {1'b0, b};
      OP_SUB:  r = {(a < b), a - b};
      OP_AND:  r = {1'b0, a & b};
      OP_OR:   r = {1'b0, a | b};
      OP_XOR:  r = {1'b0, a ^ b};
      OP_MOV:  r = {1'b0, a};
      OP_NOT:  r = {1'b0, ~a};
      OP_SHL:  r = {1'b0, a[14:0], 1'b0};
      OP_SHR:  r = {2'b00, a[15:1]};
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic logic is_alu_op(input logic [3:0] op);
    return (op >= OP_ADD) && (op <= OP_SHR);
  endfunction

  state_t      state_q, state_d;
  logic [3:0]  op_q, op_d;
  logic [3:0]  da_q, da_d;
  logic        instr_ready_q, instr_ready_d;
  logic        rf_en_q, rf_en_d;
  logic [1:0]  rf_rw_q, rf_rw_d;
  logic [3:0]  rf_da_q, rf_da_d;
  logic [3:0]  rf_aa_q, rf_aa_d;
  logic [3:0]  rf_ba_q, rf_ba_d;
  logic [15:0] rf_d_q, rf_d_d;
  logic        done_q, done_d;
  logic        illegal_q, illegal_d;
  logic        zero_q, zero_d;
  logic        carry_q, carry_d;
  logic [16:0] alu_res;

  assign alu_res = alu_op(op_q, rf_a, rf_b);

  // Next-state and next-output logic; every output is registered, so each
  // state's outputs are set up on the edge that enters that state.
  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    da_d          = da_q;
    instr_ready_d = 1'b0;
    rf_en_d       = 1'b0;
    rf_rw_d       = RW_IDLE;
    rf_da_d       = rf_da_q;
    rf_aa_d       = rf_aa_q;
    rf_ba_d       = rf_ba_q;
    rf_d_d        = rf_d_q;
    done_d        = 1'b0;
    illegal_d     = 1'b0;
    zero_d        = zero_q;
    carry_d       = carry_q;
    case (state_q)
      S_IDLE: begin
        instr_ready_d = 1'b1;
        if (instr_valid && instr_ready_q) begin
          op_d          = instr[15:12];
          da_d          = instr[11:8];
          instr_ready_d = 1'b0;
          if (is_alu_op(instr[15:12])) begin
            state_d = S_READ;
            rf_en_d = 1'b1;
            rf_rw_d = RW_READ;
            rf_aa_d = instr[7:4];
            rf_ba_d = instr[3:0];
          end else if (instr[15:12] == OP_LDI) begin
            state_d = S_WRITE;
            rf_en_d = 1'b1;
            rf_rw_d = RW_WRITE;
            rf_da_d = instr[11:8];
            rf_d_d  = {8'h00, instr[7:0]};
          end else begin
            state_d   = S_DONE;
            done_d    = 1'b1;
            illegal_d = (instr[15:12] != OP_NOP);
          end
        end
      end
      S_READ: begin
        state_d = S_EXEC;
      end
      S_EXEC: begin
        state_d = S_WRITE;
        rf_en_d = 1'b1;
        rf_rw_d = RW_WRITE;
        rf_da_d = da_q;
        rf_d_d  = alu_res[15:0];
        zero_d  = (alu_res[15:0] == 16'h0000);
        carry_d = alu_res[16];
      end
      S_WRITE: begin
        state_d = S_DONE;
        done_d  = 1'b1;
      end
      S_DONE: begin
        state_d       = S_IDLE;
        instr_ready_d = 1'b1;
      end
      default: begin
        state_d       = S_IDLE;
        instr_ready_d = 1'b1;
      end
    endcase
  end

  // State and output registers; reset aborts any instruction in flight.
  always_ff @(posedge clk_main or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      op_q          <= OP_NOP;
      da_q          <= '0;
      instr_ready_q <= 1'b1;
      rf_en_q       <= 1'b0;
      rf_rw_q       <= RW_IDLE;
      rf_da_q       <= '0;
      rf_aa_q       <= '0;
      rf_ba_q       <= '0;
      rf_d_q        <= '0;
      done_q        <= 1'b0;
      illegal_q     <= 1'b0;
      zero_q        <= 1'b0;
      carry_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      da_q          <= da_d;
      instr_ready_q <= instr_ready_d;
      rf_en_q       <= rf_en_d;
      rf_rw_q       <= rf_rw_d;
      rf_da_q       <= rf_da_d;
      rf_aa_q       <= rf_aa_d;
      rf_ba_q       <= rf_ba_d;
      rf_d_q        <= rf_d_d;
      done_q        <= done_d;
      illegal_q     <= illegal_d;
      zero_q        <= zero_d;
      carry_q       <= carry_d;
    end
  end

  assign instr_ready = instr_ready_q;
  assign rf_en       = rf_en_q;
  assign rf_rw       = rf_rw_q;
  assign rf_da       = rf_da_q;
  assign rf_aa       = rf_aa_q;
  assign rf_ba       = rf_ba_q;
  assign rf_d        = rf_d_q;
  assign done        = done_q;
  assign illegal     = illegal_q;
  assign zero        = zero_q;
  assign carry       = carry_q;

endmodule

// File: tb/tb_regfile_sequencer.sv
// Bench for regfile_sequencer: a register-file model supplies operands and
// absorbs writes; a per-instruction reference model predicts timing, writes,
// register contents and flags.
module tb_regfile_sequencer;

  logic        clk_main = 1'b0;
  logic        reset;
  logic [15:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        rf_en;
  logic [1:0]  rf_rw;
  logic [3:0]  rf_da, rf_aa, rf_ba;
  logic [15:0] rf_d;
  logic [15:0] rf_a, rf_b;
  logic        done, illegal, zero, carry;

  int checks = 0;
  int failures = 0;

  // Register-file model contents plus a side port used to preload values.
  logic [15:0] mem [16];
  logic        poke_en;
  logic [3:0]  poke_addr;
  logic [15:0] poke_data;

  // Reference state.
  logic [15:0] ref_regs [16];
  logic        ref_zero, ref_carry;

  regfile_sequencer dut (
    .clk_main    (clk_main),
    .reset       (reset),
    .instr       (instr),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .rf_en       (rf_en),
    .rf_rw       (rf_rw),
    .rf_da       (rf_da),
    .rf_aa       (rf_aa),
    .rf_ba       (rf_ba),
    .rf_d        (rf_d),
    .rf_a        (rf_a),
    .rf_b        (rf_b),
    .done        (done),
    .illegal     (illegal),
    .zero        (zero),
    .carry       (carry)
  );

  always #5 clk_main = ~clk_main;

  // Register file: synchronous write, read data registered on the read edge.
  always @(posedge clk_main) begin
    if (poke_en) mem[poke_addr] <= poke_data;
    else if (rf_en && rf_rw == 2'b01) mem[rf_da] <= rf_d;
    if (rf_en && rf_rw == 2'b10) begin
      rf_a <= mem[rf_aa];
      rf_b <= mem[rf_ba];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [3:0] a, input logic [15:0] d);
    poke_en = 1'b1; poke_addr = a; poke_data = d;
    @(posedge clk_main); #1;
    poke_en = 1'b0;
    ref_regs[a] = d;
  endtask

  // Issue one instruction from IDLE, observe it to retirement and compare
  // against the reference model. Junk instructions are offered while busy.
  task automatic issue(input logic [15:0] ins);
    int lat = 0, wr_cyc = 0, rd_cyc = 0, en_cnt = 0, rdy_busy = 0;
    logic [3:0] wda = 0, raa = 0, rba = 0;
    logic [15:0] wd = 0;
    logic ill = 0;
    int op, e_lat, e_wr, e_rd, e_en, a, b, r, c;
    logic [3:0] da, aa, ba;
    op = int'(ins[15:12]); da = ins[11:8]; aa = ins[7:4]; ba = ins[3:0];
    check("ready_before_issue", instr_ready, 1);
    instr = ins; instr_valid = 1'b1;
    @(posedge clk_main); #1;
    instr = 16'($urandom);
    for (int cyc = 1; cyc <= 8; cyc++) begin
      if (instr_ready) rdy_busy++;
      if (rf_en) en_cnt++;
      if (rf_en && rf_rw == 2'b10) begin rd_cyc = cyc; raa = rf_aa; rba = rf_ba; end
      if (rf_en && rf_rw == 2'b01) begin wr_cyc = cyc; wda = rf_da; wd = rf_d; end
      if (done) begin lat = cyc; ill = illegal; break; end
      @(posedge clk_main); #1;
      instr = 16'($urandom);
    end
    instr_valid = 1'b0;
    @(posedge clk_main); #1;

    // Reference model.
    e_lat = 1; e_wr = 0; e_rd = 0; e_en = 0; r = 0; c = 0;
    a = int'(ref_regs[aa]); b = int'(ref_regs[ba]);
    if (op >= 1 && op <= 9) begin
      e_lat = 4; e_wr = 3; e_rd = 1; e_en = 2;
      case (op)
        1: begin r = a + b; c = (r > 65535) ? 1 : 0; end
        2: begin r = a - b; c = (a < b) ? 1 : 0; end
        3: r = a & b;
        4: r = a | b;
        5: r = a ^ b;
        6: r = a;
        7: r = 65535 - a;
        8: r = a * 2;
        default: r = a / 2;
      endcase
      r = r & 32'hFFFF;
      ref_regs[da] = 16'(r);
      ref_zero = (r == 0);
      ref_carry = c[0];
    end else if (op == 10) begin
      e_lat = 2; e_wr = 1; e_en = 1;
      r = int'(ins[7:0]);
      ref_regs[da] = 16'(r);
    end

    check($sformatf("latency_%h", ins), lat, e_lat);
    check($sformatf("illegal_%h", ins), {31'd0, ill}, (op >= 11) ? 1 : 0);
    check($sformatf("rf_en_cycles_%h", ins), en_cnt, e_en);
    check($sformatf("ready_while_busy_%h", ins), rdy_busy, 0);
    check($sformatf("write_cycle_%h", ins), wr_cyc, e_wr);
    check($sformatf("read_cycle_%h", ins), rd_cyc, e_rd);
    if (e_wr != 0) begin
      check($sformatf("write_da_%h", ins), {28'd0, wda}, {28'd0, da});
      check($sformatf("write_data_%h", ins), {16'd0, wd}, r);
      check($sformatf("regfile_%h", ins), {16'd0, mem[da]}, {16'd0, ref_regs[da]});
    end
    if (e_rd != 0) begin
      check($sformatf("read_aa_%h", ins), {28'd0, raa}, {28'd0, aa});
      check($sformatf("read_ba_%h", ins), {28'd0, rba}, {28'd0, ba});
    end
    check($sformatf("zero_%h", ins), {31'd0, zero}, {31'd0, ref_zero});
    check($sformatf("carry_%h", ins), {31'd0, carry}, {31'd0, ref_carry});
  endtask

  initial begin
    int n_wr, n_done, n_en;
    reset = 1'b0; instr = '0; instr_valid = 1'b0;
    poke_en = 1'b0; poke_addr = '0; poke_data = '0;
    ref_zero = 1'b0; ref_carry = 1'b0;
    #2 reset = 1'b1;
    #1;
    check("reset_rf_en", rf_en, 0);
    check("reset_rf_rw", rf_rw, 0);
    check("reset_addrs", {rf_da, rf_aa, rf_ba}, 0);
    check("reset_rf_d", rf_d, 0);
    check("reset_done_illegal", {done, illegal}, 0);
    check("reset_flags", {zero, carry}, 0);

    // Preload every register while reset is held.
    for (int i = 0; i < 16; i++) poke(4'(i), 16'($urandom));
    poke(4'd1, 16'hFFFF);
    poke(4'd2, 16'h0001);
    reset = 1'b0;
    check("ready_after_reset", instr_ready, 1);

    // First accept on the first edge after release.
    issue(16'hA35A);
    issue(16'h1412);
    check("add_r4_value", mem[4], 16'h0000);
    check("add_flags", {zero, carry}, 2'b11);
    poke(4'd1, 16'h0003);
    poke(4'd2, 16'h0005);
    issue(16'h2512);
    check("sub_r5_value", mem[5], 16'hFFFE);
    check("sub_flags", {zero, carry}, 2'b01);
    issue(16'hF123);
    issue(16'h1333);
    issue(16'h0000);
    issue(16'h8101);
    issue(16'h9202);

    for (int k = 0; k < 40; k++) issue(16'($urandom));

    // NOP stream with valid held high: accept every other cycle.
    instr = 16'h0000; instr_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      check($sformatf("nop_stream_ready_%0d", k), instr_ready, (k % 2 == 0) ? 1 : 0);
      check($sformatf("nop_stream_done_%0d", k), done, (k % 2 == 1) ? 1 : 0);
      @(posedge clk_main); #1;
    end
    instr_valid = 1'b0;

    // Reset during EXEC of an ADD aborts it.
    poke(4'd1, 16'h1234);
    poke(4'd2, 16'h0F0F);
    instr = 16'h1412; instr_valid = 1'b1;
    @(posedge clk_main); #1;
    instr_valid = 1'b0;
    @(posedge clk_main); #1;
    reset = 1'b1;
    #1;
    check("abort_rf_en", rf_en, 0);
    check("abort_rf_rw", rf_rw, 0);
    check("abort_addrs", {rf_da, rf_aa, rf_ba}, 0);
    check("abort_rf_d", rf_d, 0);
    check("abort_done", {done, illegal}, 0);
    check("abort_flags", {zero, carry}, 0);
    ref_zero = 1'b0; ref_carry = 1'b0;
    @(posedge clk_main); #1;
    reset = 1'b0;
    check("abort_ready", instr_ready, 1);
    n_wr = 0; n_done = 0; n_en = 0;
    for (int k = 0; k < 6; k++) begin
      if (rf_en && rf_rw == 2'b01) n_wr++;
      if (rf_en) n_en++;
      if (done) n_done++;
      @(posedge clk_main); #1;
    end
    check("abort_no_write", n_wr, 0);
    check("abort_no_rf_en", n_en, 0);
    check("abort_no_done", n_done, 0);
    check("abort_r4_kept", mem[4], ref_regs[4]);
    issue(16'h1412);
    issue(16'hA7C3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
